// File: rtl/qupls_regread_arbiter.sv
// Register-file read-port arbiter: rotating priority with age-based starvation override.
// Optional QUPLS_RDPORT_ZERO_BYPASS_EN grants register-0 reads without using a port.
module qupls_regread_arbiter #(
  parameter int unsigned NREQ       = 8,
  parameter int unsigned NPORT      = 4,
  parameter int unsigned AREGW      = 9,
  parameter int unsigned STARVE_LIM = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall,
  input  logic [NREQ-1:0]                  req,
  input  logic [NREQ*AREGW-1:0]            req_reg,
  output logic [NREQ-1:0]                  gnt,
  output logic [NPORT-1:0]                 rp_v,
  output logic [NPORT*AREGW-1:0]           rp_reg,
  output logic [NPORT*$clog2(NREQ)-1:0]    rp_src
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned PW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [3:0]  Lim = 4'(STARVE_LIM);

  logic [IW-1:0]                  ptr_q, ptr_d;
  logic [NREQ-1:0][3:0]           age_q, age_d;
  logic [NREQ-1:0]                elig, sel;
  logic [NPORT-1:0]               v_d;
  logic [NPORT-1:0][AREGW-1:0]    reg_d;
  logic [NPORT-1:0][IW-1:0]       src_d;
  logic [CW-1:0]                  used;
  logic [IW-1:0]                  idx;

  always_comb begin
    elig  = req & ~gnt;
    sel   = '0;
    v_d   = '0;
    reg_d = '0;
    src_d = '0;
    used  = '0;
    ptr_d = ptr_q;
    idx   = '0;
`ifdef QUPLS_RDPORT_ZERO_BYPASS_EN
    for (int i = 0; i < NREQ; i++) begin
      if (elig[i] && req_reg[i*AREGW +: AREGW] == '0) sel[i] = 1'b1;
    end
`endif
    // Pass 0 takes only starved requesters, pass 1 everything still eligible.
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = ptr_q + IW'(k);
        if (elig[idx] && !sel[idx] && (p == 1 || age_q[idx] == Lim) && used < CW'(NPORT)) begin
          sel[idx]             = 1'b1;
          v_d[used[PW-1:0]]    = 1'b1;
          reg_d[used[PW-1:0]]  = req_reg[32'(idx)*AREGW +: AREGW];
          src_d[used[PW-1:0]]  = idx;
          used                 = used + CW'(1);
          ptr_d                = idx + IW'(1);
        end
      end
    end
  end

  always_comb begin
    age_d = age_q;
    for (int i = 0; i < NREQ; i++) begin
      if (!req[i] || sel[i]) begin
        age_d[i] = '0;
      end else if (age_q[i] != Lim) begin
        age_d[i] = age_q[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt    <= '0;
      rp_v   <= '0;
      rp_reg <= '0;
      rp_src <= '0;
      ptr_q  <= '0;
      age_q  <= '0;
    end else if (stall) begin
      gnt  <= '0;
      rp_v <= '0;
    end else begin
      gnt    <= sel;
      rp_v   <= v_d;
      rp_reg <= reg_d;
      rp_src <= src_d;
      ptr_q  <= ptr_d;
      age_q  <= age_d;
    end
  end

endmodule

// File: tb/tb_qupls_regread_arbiter.sv
// Scoreboard bench: default arbiter plus a single-port instance for starvation priority.
`timescale 1ns/1ps
module tb_qupls_regread_arbiter;

  typedef struct packed {
    logic [7:0]  g;
    logic [3:0]  v;
    logic [35:0] r;
    logic [11:0] s;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [7:0]  req = '0;
  logic [71:0] req_reg = '0;
  logic [7:0]  gnt;
  logic [3:0]  rp_v;
  logic [35:0] rp_reg;
  logic [11:0] rp_src;

  logic [7:0]  req1 = '0;
  logic [71:0] req_reg1;
  logic [7:0]  gnt1;
  logic [0:0]  rp_v1;
  logic [8:0]  rp_reg1;
  logic [2:0]  rp_src1;

  logic [8:0]  regtab0 [8];
  exp_t        q0[$];
  exp_t        q1[$];
  int          applied = 0;
  int          miscompares = 0;

  qupls_regread_arbiter u_dut (
    .clk(clk), .rst(rst), .stall(stall), .req(req), .req_reg(req_reg),
    .gnt(gnt), .rp_v(rp_v), .rp_reg(rp_reg), .rp_src(rp_src)
  );

  qupls_regread_arbiter #(.NPORT(1)) u_dut1 (
    .clk(clk), .rst(rst), .stall(1'b0), .req(req1), .req_reg(req_reg1),
    .gnt(gnt1), .rp_v(rp_v1), .rp_reg(rp_reg1), .rp_src(rp_src1)
  );

  function automatic exp_t mk(input logic [7:0] g, input logic [3:0] v,
                              input int s0, input int s1, input int s2, input int s3);
    exp_t e;
    int   s[4];
    s = '{s0, s1, s2, s3};
    e = '0;
    e.g = g;
    e.v = v;
    for (int p = 0; p < 4; p++) begin
      if (s[p] >= 0) begin
        e.r[p*9 +: 9] = regtab0[s[p]];
        e.s[p*3 +: 3] = 3'(s[p]);
      end
    end
    return e;
  endfunction

  function automatic exp_t mk1(input logic [7:0] g, input int s0);
    exp_t e;
    e = '0;
    e.g = g;
    if (s0 >= 0) begin
      e.v[0]   = 1'b1;
      e.r[8:0] = 9'(20 + s0);
      e.s[2:0] = 3'(s0);
    end
    return e;
  endfunction

  task automatic step0(input logic r, input logic st, input logic [7:0] rq, input exp_t e);
    @(negedge clk);
    rst   = r;
    stall = st;
    req   = rq;
    req1  = '0;
    for (int i = 0; i < 8; i++) req_reg[i*9 +: 9] = regtab0[i];
    q0.push_back(e);
  endtask

  task automatic step1(input logic r, input logic [7:0] rq, input exp_t e);
    @(negedge clk);
    rst   = r;
    stall = 1'b0;
    req   = '0;
    req1  = rq;
    q1.push_back(e);
  endtask

  // Monitor: compare every cycle that has an expectation queued.
  initial begin
    exp_t e, got;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e   = q0.pop_front();
        got = {gnt, rp_v, rp_reg, rp_src};
        applied++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL arb4 vec %0d: got gnt=%h v=%h reg=%h src=%h, want gnt=%h v=%h reg=%h src=%h",
                   applied, got.g, got.v, got.r, got.s, e.g, e.v, e.r, e.s);
        end
      end
      if (q1.size() > 0) begin
        e   = q1.pop_front();
        got = {gnt1, 3'b000, rp_v1, 27'd0, rp_reg1, 9'd0, rp_src1};
        applied++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL arb1 vec %0d: got gnt=%h v=%h reg=%h src=%h, want gnt=%h v=%h reg=%h src=%h",
                   applied, got.g, got.v, got.r, got.s, e.g, e.v, e.r, e.s);
        end
      end
    end
  end

  initial begin
    exp_t z;
    for (int i = 0; i < 8; i++) begin
      regtab0[i] = 9'(10 + i);
      req_reg1[i*9 +: 9] = 9'(20 + i);
    end
    regtab0[0] = 9'd5;
    z = mk(8'h00, 4'h0, -1, -1, -1, -1);

    // Single-port instance: a starved requester beats a fresh one at the pointer.
    step1(1'b1, 8'h00, mk1(8'h00, -1));
    step1(1'b0, 8'h23, mk1(8'h01, 0));
    step1(1'b0, 8'h22, mk1(8'h02, 1));
    step1(1'b0, 8'h24, mk1(8'h04, 2));
    step1(1'b0, 8'h28, mk1(8'h20, 5));
    step1(1'b0, 8'h08, mk1(8'h08, 3));
    step1(1'b0, 8'h00, mk1(8'h00, -1));

    // Reset with pending requests, then a single request.
    step0(1'b1, 1'b0, 8'hFF, z);
    step0(1'b1, 1'b0, 8'h00, z);
    step0(1'b0, 1'b0, 8'h01, mk(8'h01, 4'h1, 0, -1, -1, -1));
    // Stall: no grants, port data held, pointer held at 1.
    step0(1'b0, 1'b1, 8'h0F, mk(8'h00, 4'h0, 0, -1, -1, -1));
    step0(1'b0, 1'b1, 8'h0F, mk(8'h00, 4'h0, 0, -1, -1, -1));
    step0(1'b0, 1'b1, 8'h0F, mk(8'h00, 4'h0, 0, -1, -1, -1));
    step0(1'b0, 1'b0, 8'h0F, mk(8'h0F, 4'hF, 1, 2, 3, 0));
    step0(1'b0, 1'b0, 8'h00, z);
    // Oversubscription from a freshly reset pointer.
    step0(1'b1, 1'b0, 8'hFF, z);
    step0(1'b0, 1'b0, 8'hFF, mk(8'h0F, 4'hF, 0, 1, 2, 3));
    step0(1'b0, 1'b0, 8'hF0, mk(8'hF0, 4'hF, 4, 5, 6, 7));
    step0(1'b0, 1'b0, 8'h00, z);
    step0(1'b0, 1'b0, 8'hFF, mk(8'h0F, 4'hF, 0, 1, 2, 3));
    // Reset while grants are in flight; scheduling restarts at requester 0.
    step0(1'b1, 1'b0, 8'hF0, z);
    step0(1'b0, 1'b0, 8'hFF, mk(8'h0F, 4'hF, 0, 1, 2, 3));
    step0(1'b0, 1'b0, 8'hF0, mk(8'hF0, 4'hF, 4, 5, 6, 7));
    step0(1'b0, 1'b0, 8'h00, z);
    // Register-0 request.
    regtab0[0] = 9'd0;
`ifdef QUPLS_RDPORT_ZERO_BYPASS_EN
    step0(1'b0, 1'b0, 8'h1F, mk(8'h1F, 4'hF, 1, 2, 3, 4));
`else
    step0(1'b0, 1'b0, 8'h1F, mk(8'h0F, 4'hF, 0, 1, 2, 3));
`endif
    step0(1'b1, 1'b0, 8'h00, z);

    repeat (3) @(negedge clk);
    if (q0.size() + q1.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", q0.size() + q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
